// File: rtl/muldiv_unit.sv
// Iterative 16-bit unsigned multiply/divide unit (shift-add MUL, restoring DIV).
// Define MULDIV_DIV_EN to compile in the divider; otherwise DIV ops complete at once with err.
module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [15:0] opa,
   input  logic [15:0] opb,
   input  logic [2:0]  dest,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic [2:0]  writeregsel,
   output logic        write,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  op_q, op_d;
   logic [15:0] b_q, b_d;
   logic [31:0] p_q, p_d;
   logic [2:0]  dest_q, dest_d;
   logic [15:0] res_q, res_d;
   logic [2:0]  rsel_q, rsel_d;
   logic        err_q, err_d;
   logic        wr_q, wr_d;

   // p_q holds {hi, multiplier} for MUL and {remainder, quotient} for DIV
   logic [16:0] mul_sum;
   logic [31:0] mul_step;
   logic [31:0] step;

   assign mul_sum  = {1'b0, p_q[31:16]} + (p_q[0] ? {1'b0, b_q} : 17'd0);
   assign mul_step = {mul_sum, p_q[15:1]};

`ifdef MULDIV_DIV_EN
   logic [16:0] div_shf;
   logic [15:0] div_dif;
   logic        div_ge;
   logic [31:0] div_step;

   assign div_shf  = {p_q[31:16], p_q[15]};
   assign div_ge   = div_shf >= {1'b0, b_q};
   assign div_dif  = div_shf[15:0] - b_q;
   assign div_step = div_ge ? {div_dif, p_q[14:0], 1'b1}
                            : {div_shf[15:0], p_q[14:0], 1'b0};
   assign step     = op_q[1] ? div_step : mul_step;
`else
   assign step     = mul_step;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      b_d     = b_q;
      p_d     = p_q;
      dest_d  = dest_q;
      res_d   = res_q;
      rsel_d  = rsel_q;
      err_d   = err_q;
      wr_d    = wr_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               dest_d  = dest;
               b_d     = op[1] ? opb : opa;
               p_d     = {16'h0000, op[1] ? opa : opb};
               cnt_d   = 4'd0;
               state_d = S_BUSY;
`ifndef MULDIV_DIV_EN
               if (op[1]) begin
                  res_d   = 16'h0000;
                  rsel_d  = dest;
                  err_d   = 1'b1;
                  wr_d    = 1'b0;
                  state_d = S_DONE;
               end
`endif
            end
         end
         S_BUSY: begin
            p_d   = step;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               res_d   = op_q[0] ? step[31:16] : step[15:0];
               rsel_d  = dest_q;
               err_d   = op_q[1] & (b_q == 16'h0000);
               wr_d    = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         op_q    <= 2'd0;
         b_q     <= 16'h0000;
         p_q     <= 32'h0;
         dest_q  <= 3'd0;
         res_q   <= 16'h0000;
         rsel_q  <= 3'd0;
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         b_q     <= b_d;
         p_q     <= p_d;
         dest_q  <= dest_d;
         res_q   <= res_d;
         rsel_q  <= rsel_d;
         err_q   <= err_d;
         wr_q    <= wr_d;
      end
   end

   assign busy        = state_q != S_IDLE;
   assign done        = state_q == S_DONE;
   assign write       = done & wr_q;
   assign err         = done & err_q;
   assign result      = res_q;
   assign writeregsel = rsel_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Expectations follow MULDIV_DIV_EN when it is defined for the build.
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [15:0] opa;
   logic [15:0] opb;
   logic [2:0]  dest;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic [2:0]  writeregsel;
   logic        write;
   logic        err;

   int vectors;
   int miscompares;

   muldiv_unit dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .opa         (opa),
      .opb         (opb),
      .dest        (dest),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .writeregsel (writeregsel),
      .write       (write),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives a one-cycle start pulse; returns at the negedge of cycle 1
   task automatic issue(input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [2:0] d);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      opa   = a;
      opb   = b;
      dest  = d;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Returns cycle index (1 = first cycle after acceptance) of done, 40 on timeout
   task automatic wait_done(output int lat);
      lat = 1;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      rst   = 1'b1;
      start = 1'b0;
      op    = 2'd0;
      opa   = 16'h0;
      opb   = 16'h0;
      dest  = 3'd0;
      repeat (2) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || write !== 1'b0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: busy/done/write/err=%b%b%b%b want 0000",
                  busy, done, write, err);
      end
      vectors++;
      if (result !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_result: got %h want 0000", result);
      end
      vectors++;
      if (writeregsel !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_wsel: got %0d want 0", writeregsel);
      end
      rst = 1'b0;
   endtask

   task automatic test_mul_low;
      int lat;
      issue(2'b00, 16'h1234, 16'h0010, 3'd5);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL mul_c1: done/busy=%b%b want 01", done, busy);
      end
      wait_done(lat);
      vectors++;
      if (lat != 17) begin
         miscompares++;
         $display("FAIL mul_latency: got %0d want 17", lat);
      end
      vectors++;
      if (result !== 16'h2340 || writeregsel !== 3'd5) begin
         miscompares++;
         $display("FAIL mul_low: res=%h sel=%0d want 2340 5", result, writeregsel);
      end
      vectors++;
      if (write !== 1'b1 || err !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL mul_low_flags: write/err/busy=%b%b%b want 101",
                  write, err, busy);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || write !== 1'b0 || result !== 16'h2340) begin
         miscompares++;
         $display("FAIL mul_idle: busy=%b done=%b write=%b res=%h want 000 2340",
                  busy, done, write, result);
      end
   endtask

   task automatic test_mul_ffff;
      int lat;
      issue(2'b01, 16'hFFFF, 16'hFFFF, 3'd3);
      wait_done(lat);
      vectors++;
      if (lat != 17 || result !== 16'hFFFE) begin
         miscompares++;
         $display("FAIL mul_hi: lat=%0d res=%h want 17 FFFE", lat, result);
      end
      issue(2'b00, 16'hFFFF, 16'hFFFF, 3'd4);
      wait_done(lat);
      vectors++;
      if (lat != 17 || result !== 16'h0001 || writeregsel !== 3'd4) begin
         miscompares++;
         $display("FAIL mul_lo_ffff: lat=%0d res=%h sel=%0d want 17 0001 4",
                  lat, result, writeregsel);
      end
   endtask

   task automatic test_div;
      int lat;
`ifdef MULDIV_DIV_EN
      issue(2'b10, 16'h0064, 16'h0007, 3'd1);
      wait_done(lat);
      vectors++;
      if (lat != 17 || result !== 16'h000E || err !== 1'b0 || write !== 1'b1) begin
         miscompares++;
         $display("FAIL div_quo: lat=%0d res=%h err=%b wr=%b want 17 000E 0 1",
                  lat, result, err, write);
      end
      issue(2'b11, 16'h0064, 16'h0007, 3'd2);
      wait_done(lat);
      vectors++;
      if (lat != 17 || result !== 16'h0002 || err !== 1'b0 || write !== 1'b1) begin
         miscompares++;
         $display("FAIL div_rem: lat=%0d res=%h err=%b wr=%b want 17 0002 0 1",
                  lat, result, err, write);
      end
`else
      issue(2'b10, 16'h0064, 16'h0007, 3'd1);
      wait_done(lat);
      vectors++;
      if (lat != 1 || result !== 16'h0000 || err !== 1'b1 || write !== 1'b0) begin
         miscompares++;
         $display("FAIL nodiv_quo: lat=%0d res=%h err=%b wr=%b want 1 0000 1 0",
                  lat, result, err, write);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL nodiv_idle: busy=%b done=%b want 00", busy, done);
      end
`endif
   endtask

   task automatic test_div_zero;
      int lat;
`ifdef MULDIV_DIV_EN
      issue(2'b10, 16'h1234, 16'h0000, 3'd6);
      wait_done(lat);
      vectors++;
      if (lat != 17 || result !== 16'hFFFF || err !== 1'b1 || write !== 1'b1) begin
         miscompares++;
         $display("FAIL dz_quo: lat=%0d res=%h err=%b wr=%b want 17 FFFF 1 1",
                  lat, result, err, write);
      end
      issue(2'b11, 16'h1234, 16'h0000, 3'd6);
      wait_done(lat);
      vectors++;
      if (lat != 17 || result !== 16'h1234 || err !== 1'b1 || write !== 1'b1) begin
         miscompares++;
         $display("FAIL dz_rem: lat=%0d res=%h err=%b wr=%b want 17 1234 1 1",
                  lat, result, err, write);
      end
`else
      issue(2'b11, 16'h1234, 16'h0000, 3'd6);
      wait_done(lat);
      vectors++;
      if (lat != 1 || result !== 16'h0000 || err !== 1'b1 || write !== 1'b0) begin
         miscompares++;
         $display("FAIL nodiv_rem: lat=%0d res=%h err=%b wr=%b want 1 0000 1 0",
                  lat, result, err, write);
      end
`endif
      @(negedge clk);
      vectors++;
      if (err !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL err_pulse: err=%b done=%b want 00", err, done);
      end
   endtask

   task automatic test_back_to_back;
      int first_done;
      int second_done;
      logic [15:0] res1;
      logic [15:0] res2;
      logic busy18;
      logic busy19;
      first_done  = 0;
      second_done = 0;
      res1   = 16'hxxxx;
      res2   = 16'hxxxx;
      busy18 = 1'bx;
      busy19 = 1'bx;
      @(negedge clk);
      start = 1'b1;
      op    = 2'b00;
      opa   = 16'h0003;
      opb   = 16'h0005;
      dest  = 3'd2;
      for (int cyc = 1; cyc <= 36; cyc++) begin
         @(negedge clk);
         if (cyc == 5) opa = 16'h0100;
         if (cyc == 18) busy18 = busy;
         if (cyc == 19) busy19 = busy;
         if (done && first_done == 0) begin
            first_done = cyc;
            res1 = result;
         end else if (done && second_done == 0) begin
            second_done = cyc;
            res2 = result;
         end
         if (cyc == 35) start = 1'b0;
      end
      vectors++;
      if (first_done != 17 || res1 !== 16'h000F) begin
         miscompares++;
         $display("FAIL b2b_first: cyc=%0d res=%h want 17 000F", first_done, res1);
      end
      vectors++;
      if (busy18 !== 1'b0 || busy19 !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_gap: busy18=%b busy19=%b want 0 1", busy18, busy19);
      end
      vectors++;
      if (second_done != 35 || res2 !== 16'h0500) begin
         miscompares++;
         $display("FAIL b2b_second: cyc=%0d res=%h want 35 0500", second_done, res2);
      end
   endtask

   task automatic test_reset_mid;
      int hits;
      issue(2'b00, 16'hFFFF, 16'hFFFF, 3'd7);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || write !== 1'b0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_ctrl: busy/done/write/err=%b%b%b%b want 0000",
                  busy, done, write, err);
      end
      vectors++;
      if (result !== 16'h0000 || writeregsel !== 3'd0) begin
         miscompares++;
         $display("FAIL rst_mid_out: res=%h sel=%0d want 0000 0", result, writeregsel);
      end
      hits = 0;
      repeat (20) begin
         @(negedge clk);
         if (done || write || busy) hits++;
      end
      vectors++;
      if (hits != 0) begin
         miscompares++;
         $display("FAIL rst_mid_quiet: %0d active cycles want 0", hits);
      end
   endtask

   task automatic test_reset_start;
      int hits;
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      op    = 2'b00;
      opa   = 16'h0002;
      opb   = 16'h0003;
      dest  = 3'd1;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_start_busy: got %b want 0", busy);
      end
      hits = 0;
      repeat (20) begin
         @(negedge clk);
         if (done || write || busy) hits++;
      end
      vectors++;
      if (hits != 0) begin
         miscompares++;
         $display("FAIL rst_start_quiet: %0d active cycles want 0", hits);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_mul_low();
      test_mul_ffff();
      test_div();
      test_div_zero();
      test_back_to_back();
      test_reset_mid();
      test_reset_start();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
